// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings and arbiter state constants shared by the arbiter slice.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// sdram_arbit_if: stage request/grant handshakes and the muxed SDRAM command bus.
interface sdram_arbit_if;

    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        ref_req;
    logic        flag_ref_end;
    logic [3:0]  ref_cmd;
    logic [12:0] ref_addr;
    logic        wr_req;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        rd_req;
    logic        flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  ref_req, flag_ref_end, ref_cmd, ref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank
    );

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output ref_req, flag_ref_end, ref_cmd, ref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank
    );

endinterface

// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the SDRAM command bus to init, refresh, write and read stages.
module sdram_arbit
    import sdram_pkg::*;
(
    input  logic         sclk,
    input  logic         s_rst_n,
    sdram_arbit_if.slave bus
);

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   ref_en_q, ref_en_d;
    logic   wr_en_q, wr_en_d;
    logic   rd_en_q, rd_en_d;

    // Next state: refresh beats data traffic; write/read ties alternate on last_grant (1 = read went last).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_INIT:  state_d = bus.flag_init_end ? S_ARBIT : S_INIT;
            S_ARBIT: begin
                if (bus.ref_req) begin
                    state_d = S_AREF;
                end else if (bus.wr_req && (!bus.rd_req || last_grant_q)) begin
                    state_d      = S_WRITE;
                    last_grant_d = 1'b0;
                end else if (bus.rd_req) begin
                    state_d      = S_READ;
                    last_grant_d = 1'b1;
                end
            end
            S_AREF:  state_d = bus.flag_ref_end ? S_ARBIT : S_AREF;
            S_WRITE: state_d = bus.flag_wr_end ? S_ARBIT : S_WRITE;
            S_READ:  state_d = bus.flag_rd_end ? S_ARBIT : S_READ;
            default: state_d = S_ARBIT;
        endcase
        ref_en_d = (state_d == S_AREF) && (state_q != S_AREF);
        wr_en_d  = (state_d == S_WRITE) && (state_q != S_WRITE);
        rd_en_d  = (state_d == S_READ) && (state_q != S_READ);
    end

    // State, tie-break memory and one-cycle grant pulses.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= S_INIT;
            last_grant_q <= 1'b1;
            ref_en_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ref_en_q     <= ref_en_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
        end
    end

    // Command bus follows the owning stage; the arbitration state drives NOP.
    always_comb begin
        bus.sdram_cmd  = CMD_NOP;
        bus.sdram_addr = '0;
        bus.sdram_bank = '0;
        case (state_q)
            S_INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            S_AREF: begin
                bus.sdram_cmd  = bus.ref_cmd;
                bus.sdram_addr = bus.ref_addr;
            end
            S_WRITE: begin
                bus.sdram_cmd  = bus.wr_cmd;
                bus.sdram_addr = bus.wr_addr;
                bus.sdram_bank = bus.wr_bank;
            end
            S_READ: begin
                bus.sdram_cmd  = bus.rd_cmd;
                bus.sdram_addr = bus.rd_addr;
                bus.sdram_bank = bus.rd_bank;
            end
            default: ;
        endcase
    end

    assign bus.ref_en = ref_en_q;
    assign bus.wr_en  = wr_en_q;
    assign bus.rd_en  = rd_en_q;

endmodule
